// File: rtl/axis_noc_injection_mux_if.sv
// Bundle of AXIS source channels plus the flit/credit link into router port 0.
// master = sources and router side, slave = the injection mux.
interface axis_noc_injection_mux_if #(
   parameter int NUM_CHANNELS      = 4,
   parameter int TDATA_WIDTH       = 32,
   parameter int TID_WIDTH         = 2,
   parameter int TDEST_WIDTH       = 4,
   parameter int FLIT_BUFFER_DEPTH = 8
);
   localparam int DEST_WIDTH   = TDEST_WIDTH + TID_WIDTH;
   localparam int CREDIT_WIDTH = $clog2(FLIT_BUFFER_DEPTH + 1);

   logic [NUM_CHANNELS-1:0]                   axis_in_tvalid;
   logic [NUM_CHANNELS-1:0]                   axis_in_tready;
   logic [NUM_CHANNELS-1:0][TDATA_WIDTH-1:0]  axis_in_tdata;
   logic [NUM_CHANNELS-1:0]                   axis_in_tlast;
   logic [NUM_CHANNELS-1:0][TID_WIDTH-1:0]    axis_in_tid;
   logic [NUM_CHANNELS-1:0][TDEST_WIDTH-1:0]  axis_in_tdest;
   logic [TDATA_WIDTH-1:0]                    data_out;
   logic [DEST_WIDTH-1:0]                     dest_out;
   logic                                      is_tail_out;
   logic                                      send_out;
   logic                                      credit_in;
   logic [CREDIT_WIDTH-1:0]                   credit_count;
   logic [NUM_CHANNELS-1:0]                   grant_onehot;
   logic                                      credit_overflow;

   modport master (
      output axis_in_tvalid, axis_in_tdata, axis_in_tlast, axis_in_tid, axis_in_tdest, credit_in,
      input  axis_in_tready, data_out, dest_out, is_tail_out, send_out,
             credit_count, grant_onehot, credit_overflow
   );

   modport slave (
      input  axis_in_tvalid, axis_in_tdata, axis_in_tlast, axis_in_tid, axis_in_tdest, credit_in,
      output axis_in_tready, data_out, dest_out, is_tail_out, send_out,
             credit_count, grant_onehot, credit_overflow
   );
endinterface

// File: rtl/axis_noc_injection_mux.sv
// Packet-atomic round-robin merge of AXIS channels into one credit-controlled router port.
// Handshake: a beat transfers on a channel when tvalid & tready are both high at a clk_noc edge.
module axis_noc_injection_mux #(
   parameter int NUM_CHANNELS      = 4,
   parameter int TDATA_WIDTH       = 32,
   parameter int TID_WIDTH         = 2,
   parameter int TDEST_WIDTH       = 4,
   parameter int FLIT_BUFFER_DEPTH = 8
) (
   input  logic                    clk_noc,
   input  logic                    rst_n,
   axis_noc_injection_mux_if.slave bus,
   output logic                    state_dbg
);
   localparam int CH_W         = $clog2(NUM_CHANNELS);
   localparam int DEST_WIDTH   = TDEST_WIDTH + TID_WIDTH;
   localparam int CREDIT_WIDTH = $clog2(FLIT_BUFFER_DEPTH + 1);
   localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

   typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_e;

   state_e                  state_q, state_d;
   logic [CH_W-1:0]         owner_q, owner_d;
   logic [CH_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
   logic                    overflow_q, overflow_d;
   logic                    send_q, send_d;
   logic                    tail_q, tail_d;
   logic [TDATA_WIDTH-1:0]  data_q, data_d;
   logic [DEST_WIDTH-1:0]   dest_q, dest_d;

   logic [CH_W-1:0]         cand, winner, sel;
   logic                    found, has_credit, fire_any;
   logic [NUM_CHANNELS-1:0] tready, fire;

   function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] c);
      if (c == CH_W'(NUM_CHANNELS - 1)) return '0;
      return c + CH_W'(1);
   endfunction

   // Scan from the far end backwards so the candidate closest to rr_ptr is written last and wins.
   always_comb begin
      winner = rr_ptr_q;
      found  = 1'b0;
      cand   = '0;
      for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
         cand = CH_W'((int'(rr_ptr_q) + i) % NUM_CHANNELS);
         if (bus.axis_in_tvalid[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      credit_d   = credit_q;
      overflow_d = overflow_q;
      send_d     = 1'b0;
      tail_d     = tail_q;
      data_d     = data_q;
      dest_d     = dest_q;
      tready     = '0;
      has_credit = (credit_q != '0);
      sel        = (state_q == S_LOCKED) ? owner_q : winner;

      case (state_q)
         S_IDLE:   if (found && has_credit) tready[winner] = 1'b1;
         S_LOCKED: tready[owner_q] = has_credit;
         default:  tready = '0;
      endcase

      fire     = bus.axis_in_tvalid & tready;
      fire_any = |fire;

      if (fire_any) begin
         send_d = 1'b1;
         data_d = bus.axis_in_tdata[sel];
         dest_d = {bus.axis_in_tid[sel], bus.axis_in_tdest[sel]};
         tail_d = bus.axis_in_tlast[sel];
         if (bus.axis_in_tlast[sel]) begin
            state_d  = S_IDLE;
            rr_ptr_d = wrap_inc(sel);
         end else begin
            state_d = S_LOCKED;
            owner_d = sel;
         end
      end

      // A returned credit that cannot be absorbed indicates a router/mux credit mismatch.
      case ({fire_any, bus.credit_in})
         2'b10: credit_d = credit_q - CREDIT_WIDTH'(1);
         2'b01: begin
            if (credit_q == CREDIT_MAX) overflow_d = 1'b1;
            else                        credit_d   = credit_q + CREDIT_WIDTH'(1);
         end
         default: credit_d = credit_q;
      endcase
   end

   always_ff @(posedge clk_noc) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         credit_q   <= CREDIT_MAX;
         overflow_q <= 1'b0;
         send_q     <= 1'b0;
         tail_q     <= 1'b0;
         data_q     <= '0;
         dest_q     <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         credit_q   <= credit_d;
         overflow_q <= overflow_d;
         send_q     <= send_d;
         tail_q     <= tail_d;
         data_q     <= data_d;
         dest_q     <= dest_d;
      end
   end

   assign bus.axis_in_tready  = tready;
   assign bus.data_out        = data_q;
   assign bus.dest_out        = dest_q;
   assign bus.is_tail_out     = tail_q;
   assign bus.send_out        = send_q;
   assign bus.credit_count    = credit_q;
   assign bus.credit_overflow = overflow_q;
   assign bus.grant_onehot    = (state_q == S_LOCKED) ? (NUM_CHANNELS'(1) << owner_q) : '0;
   assign state_dbg           = state_q;
endmodule
